// File: rtl/dmux_arbiter_pkg.sv
// Shared constants and state encoding for the four-requester dmux arbiter.
package dmux_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned BURST_W = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } state_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/dmux_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping to 0.
module rr_pick
    import dmux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   index,
    output logic               any_valid
);

    always_comb begin
        logic [PTR_W-1:0] w_cand;
        index     = '0;
        any_valid = 1'b0;
        w_cand    = '0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = rr_ptr + PTR_W'(k);
            if (req[w_cand]) begin
                index     = w_cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmux_arbiter.sv
// Round-robin burst arbiter feeding a registered word and select into a downstream dmux.
module dmux_arbiter
    import dmux_arbiter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned NB_SEL    = 2,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*NB_SEL-1:0]    req_dest,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         out_valid,
    output logic [BUS_WIDTH-1:0]         out_data,
    output logic [NB_SEL-1:0]            out_sel,
    input  logic                         out_ready,
    output logic                         busy
);

    state_e               r_state, w_state_next;
    logic [PTR_W-1:0]     r_owner, w_owner_next;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_next;
    logic [BURST_W-1:0]   r_burst, w_burst_next;
    logic                 r_out_valid;
    logic [BUS_WIDTH-1:0] r_out_data;
    logic [NB_SEL-1:0]    r_out_sel;

    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic                 w_free;
    logic                 w_grant_en;
    logic [BURST_W-1:0]   w_burst_inc;

    rr_pick u_rr_pick (
        .req       (req),
        .rr_ptr    (r_rr_ptr),
        .index     (w_pick_idx),
        .any_valid (w_pick_any)
    );

    assign w_free      = !r_out_valid || out_ready;
    // Gated by rst_n so grant reads zero throughout a reset cycle.
    assign w_grant_en  = rst_n && (r_state == StOwn) && req[r_owner] && w_free;
    assign w_burst_inc = r_burst + BURST_W'(1);

    always_comb begin
        logic w_end;
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_rr_ptr_next = r_rr_ptr;
        w_burst_next  = r_burst;
        w_end         = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_pick_any) begin
                    w_owner_next = w_pick_idx;
                    w_burst_next = '0;
                    w_state_next = StOwn;
                end
            end
            StOwn: begin
                if (!req[r_owner]) begin
                    w_end = 1'b1;
                end else if (w_grant_en) begin
                    w_burst_next = w_burst_inc;
                    w_end        = (w_burst_inc == BURST_W'(BURST_MAX));
                end
                if (w_end) begin
                    w_rr_ptr_next = ptr_inc(r_owner);
                    w_state_next  = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_burst  <= w_burst_next;
            if (w_grant_en) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_data[r_owner*BUS_WIDTH +: BUS_WIDTH];
                r_out_sel   <= req_dest[r_owner*NB_SEL +: NB_SEL];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (w_grant_en) begin
            grant = NUM_REQ'(1) << r_owner;
        end
    end

    assign busy      = rst_n && (r_state == StOwn);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_dmux_arbiter.sv
// Directed scoreboard bench for dmux_arbiter: grants checked per cycle, words checked on accept.
module tb_dmux_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_dest;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic        busy;

    logic [7:0]  d    [4];
    logic [1:0]  dst  [4];
    logic        bump;
    word_t       exp_q[$];
    word_t       held;
    int          checks;
    int          failures;

    assign req_data = {d[3], d[2], d[1], d[0]};
    assign req_dest = {dst[3], dst[2], dst[1], dst[0]};

    dmux_arbiter #(
        .BUS_WIDTH (8),
        .NB_SEL    (2),
        .BURST_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_dest  (req_dest),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: compare grant/busy/out_valid mid-cycle, log expected word, advance.
    task automatic step(input logic [3:0] eg, input logic eb, input logic ev, input string tag);
        int idx;
        idx = 0;
        @(negedge clk);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        if (eg != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) idx = i;
            end
            held.data = d[idx];
            held.sel  = dst[idx];
            exp_q.push_back(held);
        end
        @(posedge clk);
        #1;
        if (bump) begin
            for (int i = 0; i < 4; i++) begin
                d[i]   = d[i] + 8'd1;
                dst[i] = dst[i] + 2'd1;
            end
        end
    endtask

    // Monitor: every word the downstream accepts must match the oldest expected word.
    always @(negedge clk) begin
        word_t got;
        word_t want;
        if (rst_n && out_valid && out_ready) begin
            got.data = out_data;
            got.sel  = out_sel;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mon_unexpected: got %0h expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL mon_word: got data=%0h sel=%0h expected data=%0h sel=%0h",
                             got.data, got.sel, want.data, want.sel);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        bump      = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b0;
        d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'hA5; d[3] = 8'h3C;
        dst[0] = 2'd0; dst[1] = 2'd1; dst[2] = 2'd3; dst[3] = 2'd2;
        held = '0;

        // Reset held for two cycles with all requests up.
        @(posedge clk);
        #1;
        step(4'b0000, 1'b0, 1'b0, "rst1");
        chk("rst_data", 32'(out_data), 32'h0);
        step(4'b0000, 1'b0, 1'b0, "rst2");
        chk("rst_sel", 32'(out_sel), 32'h0);

        // Single requester 2, dest 3, data A5.
        rst_n     = 1'b1;
        req       = 4'b0100;
        out_ready = 1'b1;
        step(4'b0000, 1'b0, 1'b0, "single_idle");
        step(4'b0100, 1'b1, 1'b0, "single_grant");
        req = 4'b0000;
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_sel", 32'(out_sel), 32'd3);
        step(4'b0000, 1'b1, 1'b1, "single_drop");
        step(4'b0000, 1'b0, 1'b0, "single_back");

        // Burst cap: rr_ptr is 3, so req0 wins first, then req1, then req0 again.
        bump = 1'b1;
        req  = 4'b0011;
        step(4'b0000, 1'b0, 1'b0, "b0_arb");
        step(4'b0001, 1'b1, 1'b0, "b0_g1");
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b1, "b0_g");
        step(4'b0000, 1'b0, 1'b1, "b1_arb");
        step(4'b0010, 1'b1, 1'b0, "b1_g1");
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b1, "b1_g");
        step(4'b0000, 1'b0, 1'b1, "b2_arb");
        step(4'b0001, 1'b1, 1'b0, "b2_g1");

        // Back-pressure for five cycles mid-burst: held word must not move.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b1, 1'b1, "stall");
            chk("stall_data", 32'(out_data), 32'(held.data));
            chk("stall_sel", 32'(out_sel), 32'(held.sel));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b1, "resume_g");
        step(4'b0000, 1'b0, 1'b1, "drop_arb");

        // Early drop: owner 1 leaves after two words; rr_ptr=2 must pick req2 over req0.
        step(4'b0010, 1'b1, 1'b0, "drop_g1");
        step(4'b0010, 1'b1, 1'b1, "drop_g2");
        req = 4'b0101;
        step(4'b0000, 1'b1, 1'b1, "drop_end");
        step(4'b0000, 1'b0, 1'b0, "drop_idle");
        step(4'b0100, 1'b1, 1'b0, "next_g1");
        step(4'b0100, 1'b1, 1'b1, "next_g2");

        // Reset mid-tenure with a word held and not accepted.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step(4'b0000, 1'b0, 1'b1, "rst_mid");
        exp_q.delete();
        chk("rst_mid_data", 32'(out_data), 32'h0);
        chk("rst_mid_sel", 32'(out_sel), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req       = 4'b1111;
        step(4'b0000, 1'b0, 1'b0, "post_rst_arb");
        step(4'b0001, 1'b1, 1'b0, "post_rst_g");
        req = 4'b0000;
        step(4'b0000, 1'b1, 1'b1, "post_rst_end");
        step(4'b0000, 1'b0, 1'b0, "post_rst_idle");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmux_arbiter.md
DMUX_ARBITER -- requirements
Module: dmux_arbiter

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, the data width of each requester word and of the output.
REQ-002 The block SHALL have parameter NB_SEL, default 2, the destination-select width fed to a downstream dmux with 2^NB_SEL outputs.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, the maximum words one owner may transfer per tenure (range 1..15).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 req  input  4  per-requester request; bit i set while requester i has a word to send.
REQ-007 req_data  input  4*BUS_WIDTH  requester i word in bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-008 req_dest  input  4*NB_SEL  requester i destination in bits [i*NB_SEL +: NB_SEL].
REQ-009 grant  output  4  one-hot or zero; bit i high means requester i's word is consumed this cycle.
REQ-010 out_valid  output  1  output register holds a word for the dmux.
REQ-011 out_data  output  BUS_WIDTH  word driven into the dmux in port.
REQ-012 out_sel  output  NB_SEL  value driven into the dmux sel port.
REQ-013 out_ready  input  1  downstream accepts the held word this cycle.
REQ-014 busy  output  1  high while state is OWN.

Function
REQ-015 The controller SHALL implement two states, IDLE and OWN, plus a 2-bit round-robin pointer rr_ptr and a burst counter.
REQ-016 In IDLE with any req bit set, the controller SHALL select the first set bit at or after rr_ptr (wrapping 3->0), record it as owner, clear the burst counter and enter OWN next cycle; grant SHALL be zero in IDLE.
REQ-017 In OWN, grant[owner] SHALL be asserted combinationally when req[owner]=1 and the output register is free (out_valid=0 or out_ready=1); no other grant bit SHALL ever be set.
REQ-018 On a granted cycle, out_data/out_sel SHALL load req_data/req_dest of the owner and out_valid SHALL be 1 the next cycle (grant-to-output latency one cycle).
REQ-019 While out_valid=1 and out_ready=0, out_data and out_sel SHALL remain stable.
REQ-020 On out_ready=1 with no grant, out_valid SHALL clear next cycle; on out_ready=1 with a simultaneous grant, out_valid SHALL stay 1 with the new word (one word per cycle sustained).
REQ-021 Each grant SHALL increment the burst counter; the grant that makes it equal BURST_MAX SHALL end the tenure.
REQ-022 The tenure SHALL also end in any OWN cycle where req[owner]=0.
REQ-023 On tenure end the controller SHALL set rr_ptr to (owner+1) mod 4 and return to IDLE, giving one idle arbitration cycle between tenures.
REQ-024 A requester dropping req while not owner SHALL lose nothing; requests are level-sensitive and not latched.
REQ-025 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-026 While rst_n=0 at a rising clk edge: state IDLE, rr_ptr 0, burst counter 0, out_valid 0, out_data 0, out_sel 0; grant and busy SHALL read 0 during and after that cycle.
REQ-027 Reset asserted mid-tenure SHALL discard the held output word and owner without a further grant.

Structure
REQ-028 A shared package SHALL hold NUM_REQ=4, the IDLE/OWN state encoding and the pointer width.
REQ-029 The round-robin selection SHALL be a sub-module rr_pick (inputs req and rr_ptr; outputs index and any-valid), purely combinational.
REQ-030 The output register and FSM SHALL reside in dmux_arbiter; no latches.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, out_valid=0, busy=0, out_data=0.
REQ-032 Single requester: req=4'b0100, dest=3, data=0xA5, out_ready=1 -> busy next cycle, grant=4'b0100 that cycle, out_valid=1/out_data=0xA5/out_sel=3 one cycle later.
REQ-033 Burst cap: req=4'b0011 held, out_ready=1, BURST_MAX=4 -> 4 grants to req0, one idle cycle, 4 grants to req1, then back to req0.
REQ-034 Back-pressure: out_ready=0 for 5 cycles mid-burst -> one grant then none, out_data stable 5 cycles; release -> consecutive grants resume.
REQ-035 Early drop: owner drops req after 2 words -> tenure ends, rr_ptr=owner+1, next requester granted after one idle cycle.
REQ-036 Reset mid-tenure with out_valid=1 -> next cycle out_valid=0, state IDLE, rr_ptr=0.
